// File: rtl/ahbl_master_arbiter_pkg.sv
// Shared constants and small helpers for the two-port AHB-Lite master arbiter.
package ahbl_master_arbiter_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Only NONSEQ/SEQ carry a transfer; IDLE and BUSY are dropped at the port.
   function automatic logic htrans_active(input logic [1:0] htrans);
      logic act;
      case (htrans)
         HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
         HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
         default:                   act = 1'b0;
      endcase
      return act;
   endfunction

   // Returns the winning port index; on a tie round-robin hands it to the port not granted last.
   function automatic logic arb_pick(input logic c0, input logic c1,
                                     input logic rr_mode, input logic rr_last);
      logic pick;
      if (c0 && c1) begin
         pick = rr_mode ? ~rr_last : 1'b0;
      end else begin
         pick = ~c0 & c1;
      end
      return pick;
   endfunction

endpackage

// File: rtl/ahbl_arb_port_buf.sv
// Per-port holding buffer for an address phase that could not be forwarded when it was presented.
module ahbl_arb_port_buf
   import ahbl_master_arbiter_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          capture,
   input  logic          clear,
   input  logic [AW-1:0] haddr_in,
   input  logic [2:0]    hsize_in,
   input  logic          hwrite_in,
   output logic          pend,
   output logic [AW-1:0] haddr,
   output logic [2:0]    hsize,
   output logic          hwrite
);

   // capture and clear never coincide: a live request only exists while pend is low.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         pend   <= 1'b0;
         haddr  <= '0;
         hsize  <= '0;
         hwrite <= 1'b0;
      end else if (capture) begin
         pend   <= 1'b1;
         haddr  <= haddr_in;
         hsize  <= hsize_in;
         hwrite <= hwrite_in;
      end else if (clear) begin
         pend   <= 1'b0;
      end
   end

endmodule

// File: rtl/ahbl_master_arbiter.sv
// Two-requester AHB-Lite master arbiter: P0 (CPU) and P1 (DMA) share one master port.
module ahbl_master_arbiter
   import ahbl_master_arbiter_pkg::*;
#(
   parameter int ARB_MODE = ARB_RR,
   parameter int AW       = 32,
   parameter int DW       = 32
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic [AW-1:0] P0_HADDR,
   input  logic [1:0]    P0_HTRANS,
   input  logic [2:0]    P0_HSIZE,
   input  logic          P0_HWRITE,
   input  logic [DW-1:0] P0_HWDATA,
   output logic [DW-1:0] P0_HRDATA,
   output logic          P0_HREADY,
   input  logic [AW-1:0] P1_HADDR,
   input  logic [1:0]    P1_HTRANS,
   input  logic [2:0]    P1_HSIZE,
   input  logic          P1_HWRITE,
   input  logic [DW-1:0] P1_HWDATA,
   output logic [DW-1:0] P1_HRDATA,
   output logic          P1_HREADY,
   output logic [AW-1:0] M_HADDR,
   output logic [1:0]    M_HTRANS,
   output logic [2:0]    M_HSIZE,
   output logic          M_HWRITE,
   output logic [DW-1:0] M_HWDATA,
   input  logic [DW-1:0] M_HRDATA,
   input  logic          M_HREADY
);

   // Handshake: an address phase on either side is taken at a rising edge where its
   // HREADY is 1; while HREADY is 0 the master holds address, control and HWDATA.

   logic          dp_valid;
   logic          dp_owner;
   logic          dp_write;
   logic          lock;
   logic          lock_port;
   logic          rr_last;

   logic          pend0, pend1;
   logic [AW-1:0] pb_haddr0, pb_haddr1;
   logic [2:0]    pb_hsize0, pb_hsize1;
   logic          pb_hwrite0, pb_hwrite1;

   logic          hready0, hready1;
   logic          live0, live1;
   logic          cand0, cand1, any_cand;
   logic          sel;
   logic          accept;
   logic          cap0, cap1, clr0, clr1;
   logic [AW-1:0] m_haddr_c;
   logic [2:0]    m_hsize_c;
   logic          m_hwrite_c;

   // A pending port is stalled; the data-phase owner sees the bus HREADY.
   always_comb begin
      hready0 = 1'b1;
      if (pend0) begin
         hready0 = 1'b0;
      end else if (dp_valid && (dp_owner == 1'b0)) begin
         hready0 = M_HREADY;
      end
   end

   always_comb begin
      hready1 = 1'b1;
      if (pend1) begin
         hready1 = 1'b0;
      end else if (dp_valid && (dp_owner == 1'b1)) begin
         hready1 = M_HREADY;
      end
   end

   assign live0    = hready0 & htrans_active(P0_HTRANS);
   assign live1    = hready1 & htrans_active(P1_HTRANS);
   assign cand0    = pend0 | live0;
   assign cand1    = pend1 | live1;
   assign any_cand = cand0 | cand1;

   // While the bus is stalled the stalled port keeps the address phase so it stays stable.
   always_comb begin
      if (lock) begin
         sel = lock_port;
      end else begin
         sel = arb_pick(cand0, cand1, (ARB_MODE == ARB_RR), rr_last);
      end
   end

   always_comb begin
      m_haddr_c  = '0;
      m_hsize_c  = '0;
      m_hwrite_c = 1'b0;
      if (any_cand) begin
         if (sel == 1'b0) begin
            m_haddr_c  = pend0 ? pb_haddr0  : P0_HADDR;
            m_hsize_c  = pend0 ? pb_hsize0  : P0_HSIZE;
            m_hwrite_c = pend0 ? pb_hwrite0 : P0_HWRITE;
         end else begin
            m_haddr_c  = pend1 ? pb_haddr1  : P1_HADDR;
            m_hsize_c  = pend1 ? pb_hsize1  : P1_HSIZE;
            m_hwrite_c = pend1 ? pb_hwrite1 : P1_HWRITE;
         end
      end
   end

   assign accept = any_cand & M_HREADY;
   assign clr0   = accept & (sel == 1'b0);
   assign clr1   = accept & (sel == 1'b1);
   assign cap0   = live0 & ~clr0;
   assign cap1   = live1 & ~clr1;

   ahbl_arb_port_buf #(.AW(AW)) u_buf0 (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .capture   (cap0),
      .clear     (clr0),
      .haddr_in  (P0_HADDR),
      .hsize_in  (P0_HSIZE),
      .hwrite_in (P0_HWRITE),
      .pend      (pend0),
      .haddr     (pb_haddr0),
      .hsize     (pb_hsize0),
      .hwrite    (pb_hwrite0)
   );

   ahbl_arb_port_buf #(.AW(AW)) u_buf1 (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .capture   (cap1),
      .clear     (clr1),
      .haddr_in  (P1_HADDR),
      .hsize_in  (P1_HSIZE),
      .hwrite_in (P1_HWRITE),
      .pend      (pend1),
      .haddr     (pb_haddr1),
      .hsize     (pb_hsize1),
      .hwrite    (pb_hwrite1)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_valid  <= 1'b0;
         dp_owner  <= 1'b0;
         dp_write  <= 1'b0;
         lock      <= 1'b0;
         lock_port <= 1'b0;
         rr_last   <= 1'b1;
      end else if (M_HREADY) begin
         lock     <= 1'b0;
         dp_valid <= accept;
         if (accept) begin
            dp_owner <= sel;
            dp_write <= m_hwrite_c;
            rr_last  <= sel;
         end
      end else if (any_cand) begin
         lock      <= 1'b1;
         lock_port <= sel;
      end
   end

   assign M_HADDR   = m_haddr_c;
   assign M_HSIZE   = m_hsize_c;
   assign M_HWRITE  = m_hwrite_c;
   assign M_HTRANS  = any_cand ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign M_HWDATA  = (dp_valid && dp_write) ? (dp_owner ? P1_HWDATA : P0_HWDATA) : '0;
   assign P0_HREADY = hready0;
   assign P1_HREADY = hready1;
   assign P0_HRDATA = M_HRDATA;
   assign P1_HRDATA = M_HRDATA;

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Bench for ahbl_master_arbiter: fixed-priority and round-robin instances share one stimulus.
module tb_ahbl_master_arbiter;
   import ahbl_master_arbiter_pkg::*;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  size;
      logic        wr;
   } req_t;

   logic HCLK = 1'b0;
   logic HRESETn = 1'b0;
   always #5 HCLK = ~HCLK;

   logic [1:0][31:0] p_haddr;
   logic [1:0][1:0]  p_htrans;
   logic [1:0][2:0]  p_hsize;
   logic [1:0]       p_hwrite;
   logic [1:0][31:0] p_hwdata;
   logic [31:0]      m_hrdata;
   logic             m_hready;

   logic [1:0][31:0] o_p0_hrdata, o_p1_hrdata, o_m_haddr, o_m_hwdata;
   logic [1:0]       o_p0_hready, o_p1_hready, o_m_hwrite;
   logic [1:0][1:0]  o_m_htrans;
   logic [1:0][2:0]  o_m_hsize;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ahbl_master_arbiter #(.ARB_MODE(g), .AW(32), .DW(32)) u_dut (
         .HCLK      (HCLK),
         .HRESETn   (HRESETn),
         .P0_HADDR  (p_haddr[0]),
         .P0_HTRANS (p_htrans[0]),
         .P0_HSIZE  (p_hsize[0]),
         .P0_HWRITE (p_hwrite[0]),
         .P0_HWDATA (p_hwdata[0]),
         .P0_HRDATA (o_p0_hrdata[g]),
         .P0_HREADY (o_p0_hready[g]),
         .P1_HADDR  (p_haddr[1]),
         .P1_HTRANS (p_htrans[1]),
         .P1_HSIZE  (p_hsize[1]),
         .P1_HWRITE (p_hwrite[1]),
         .P1_HWDATA (p_hwdata[1]),
         .P1_HRDATA (o_p1_hrdata[g]),
         .P1_HREADY (o_p1_hready[g]),
         .M_HADDR   (o_m_haddr[g]),
         .M_HTRANS  (o_m_htrans[g]),
         .M_HSIZE   (o_m_hsize[g]),
         .M_HWRITE  (o_m_hwrite[g]),
         .M_HWDATA  (o_m_hwdata[g]),
         .M_HRDATA  (m_hrdata),
         .M_HREADY  (m_hready)
      );
   end

   int tests = 0;
   int fails = 0;

   // Reference model, index [g*2+p]: a port's waiting request, the bus data-phase owner,
   // the port whose transfer is stuck on a stalled bus, and the last port granted.
   req_t held_q[4][$];
   int   dp_owner[2];
   bit   dp_wr[2];
   int   stuck[2];
   int   last_win[2];
   bit   exp_hr[2][2];
   bit   any_m[2];
   int   win_m[2];
   req_t win_req[2];

   logic [0:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int g = 0; g < 2; g++) begin
         held_q[g*2].delete();
         held_q[g*2+1].delete();
         dp_owner[g] = -1;
         dp_wr[g]    = 1'b0;
         stuck[g]    = -1;
         last_win[g] = 1;
      end
   endtask

   task automatic model_eval_check(input int g);
      bit          ask[2];
      req_t        live[2];
      req_t        r;
      logic [31:0] wd;
      for (int p = 0; p < 2; p++) begin
         live[p].addr = p_haddr[p];
         live[p].size = p_hsize[p];
         live[p].wr   = p_hwrite[p];
         if (held_q[g*2+p].size() != 0) exp_hr[g][p] = 1'b0;
         else if (dp_owner[g] == p)     exp_hr[g][p] = m_hready;
         else                           exp_hr[g][p] = 1'b1;
         ask[p] = (held_q[g*2+p].size() != 0) || (exp_hr[g][p] && p_htrans[p][1]);
      end
      any_m[g] = ask[0] || ask[1];
      if (stuck[g] >= 0)          win_m[g] = stuck[g];
      else if (ask[0] && ask[1])  win_m[g] = (g == 0) ? 0 : 1 - last_win[g];
      else                        win_m[g] = ask[0] ? 0 : 1;
      r = (held_q[g*2+win_m[g]].size() != 0) ? held_q[g*2+win_m[g]][0] : live[win_m[g]];
      win_req[g] = r;
      wd = (dp_owner[g] >= 0 && dp_wr[g]) ? p_hwdata[dp_owner[g][0]] : 32'h0;
      check($sformatf("m%0d_htrans", g), 32'(o_m_htrans[g]), any_m[g] ? 32'h2 : 32'h0);
      check($sformatf("m%0d_haddr", g), o_m_haddr[g], any_m[g] ? r.addr : 32'h0);
      check($sformatf("m%0d_hsize", g), 32'(o_m_hsize[g]), any_m[g] ? 32'(r.size) : 32'h0);
      check($sformatf("m%0d_hwrite", g), 32'(o_m_hwrite[g]), any_m[g] ? 32'(r.wr) : 32'h0);
      check($sformatf("m%0d_hwdata", g), o_m_hwdata[g], wd);
      check($sformatf("m%0d_p0_hready", g), 32'(o_p0_hready[g]), 32'(exp_hr[g][0]));
      check($sformatf("m%0d_p1_hready", g), 32'(o_p1_hready[g]), 32'(exp_hr[g][1]));
      check($sformatf("m%0d_p0_hrdata", g), o_p0_hrdata[g], m_hrdata);
      check($sformatf("m%0d_p1_hrdata", g), o_p1_hrdata[g], m_hrdata);
   endtask

   task automatic model_update(input int g);
      bit   acc;
      req_t lr;
      acc = any_m[g] && m_hready;
      for (int p = 0; p < 2; p++) begin
         lr.addr = p_haddr[p];
         lr.size = p_hsize[p];
         lr.wr   = p_hwrite[p];
         if (acc && win_m[g] == p) begin
            if (held_q[g*2+p].size() != 0) void'(held_q[g*2+p].pop_front());
         end else if (exp_hr[g][p] && p_htrans[p][1] && held_q[g*2+p].size() == 0) begin
            held_q[g*2+p].push_back(lr);
         end
      end
      if (m_hready) begin
         stuck[g] = -1;
         if (acc) begin
            dp_owner[g] = win_m[g];
            dp_wr[g]    = win_req[g].wr;
            last_win[g] = win_m[g];
         end else begin
            dp_owner[g] = -1;
         end
      end else if (any_m[g]) begin
         stuck[g] = win_m[g];
      end
   endtask

   task automatic settle();
      @(negedge HCLK);
      model_eval_check(0);
      model_eval_check(1);
   endtask

   task automatic advance();
      @(posedge HCLK);
      model_update(0);
      model_update(1);
      #1;
   endtask

   task automatic set_port(input int p, input logic [1:0] t, input logic [31:0] a,
                           input logic [2:0] s, input logic w);
      p_htrans[p] = t;
      p_haddr[p]  = a;
      p_hsize[p]  = s;
      p_hwrite[p] = w;
   endtask

   task automatic idle_inputs();
      set_port(0, HTRANS_IDLE, 32'h0, 3'd0, 1'b0);
      set_port(1, HTRANS_IDLE, 32'h0, 3'd0, 1'b0);
      p_hwdata = '0;
      m_hrdata = 32'h0;
      m_hready = 1'b1;
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      idle_inputs();
      #2;
      for (int g = 0; g < 2; g++) begin
         check($sformatf("rst%0d_htrans", g), 32'(o_m_htrans[g]), 32'h0);
         check($sformatf("rst%0d_haddr", g), o_m_haddr[g], 32'h0);
         check($sformatf("rst%0d_hwdata", g), o_m_hwdata[g], 32'h0);
         check($sformatf("rst%0d_p0_hready", g), 32'(o_p0_hready[g]), 32'h1);
         check($sformatf("rst%0d_p1_hready", g), 32'(o_p1_hready[g]), 32'h1);
      end
      model_reset();
      @(posedge HCLK);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
   endtask

   // Both ports issue reads and writes at once; fixed priority and a fresh round-robin both pick P0.
   task automatic both_request();
      set_port(0, HTRANS_NONSEQ, 32'h0000_0100, 3'd2, 1'b0);
      set_port(1, HTRANS_NONSEQ, 32'h2000_0000, 3'd2, 1'b1);
      settle();
      check("sim_c0_haddr", o_m_haddr[0], 32'h0000_0100);
      check("sim_c0_hwrite", 32'(o_m_hwrite[0]), 32'h0);
      advance();
   endtask

   initial begin
      bit active;
      idle_inputs();
      do_reset();

      // Uncontended P1 write passes straight through.
      set_port(1, HTRANS_NONSEQ, 32'h2000_0010, 3'd2, 1'b1);
      settle();
      check("t1_haddr", o_m_haddr[1], 32'h2000_0010);
      check("t1_p1_hready_a", 32'(o_p1_hready[1]), 32'h1);
      advance();
      set_port(1, HTRANS_IDLE, 32'h0, 3'd0, 1'b0);
      p_hwdata[1] = 32'hA5A5_0001;
      settle();
      check("t1_hwdata", o_m_hwdata[1], 32'hA5A5_0001);
      check("t1_p1_hready_d", 32'(o_p1_hready[1]), 32'h1);
      advance();
      settle();
      advance();

      // Simultaneous requests on the fixed-priority instance, with read data routed to P0.
      do_reset();
      both_request();
      set_port(0, HTRANS_IDLE, 32'h0, 3'd0, 1'b0);
      set_port(1, HTRANS_IDLE, 32'h0, 3'd0, 1'b0);
      p_hwdata[1] = 32'h5A5A_0002;
      m_hrdata    = 32'hDEAD_0001;
      settle();
      check("t2_p1_hready_wait", 32'(o_p1_hready[0]), 32'h0);
      check("t2_p0_hready", 32'(o_p0_hready[0]), 32'h1);
      check("t2_p0_hrdata", o_p0_hrdata[0], 32'hDEAD_0001);
      check("t2_p1_haddr", o_m_haddr[0], 32'h2000_0000);
      check("t2_p1_hwrite", 32'(o_m_hwrite[0]), 32'h1);
      advance();
      settle();
      check("t2_p1_hready_done", 32'(o_p1_hready[0]), 32'h1);
      check("t2_p1_hwdata", o_m_hwdata[0], 32'h5A5A_0002);
      advance();

      // Bus stall with P1's deferred write on the bus; P0's next request must wait its turn.
      do_reset();
      both_request();
      set_port(0, HTRANS_NONSEQ, 32'h0000_0104, 3'd2, 1'b0);
      set_port(1, HTRANS_IDLE, 32'h0, 3'd0, 1'b0);
      p_hwdata[1] = 32'h0BAD_F00D;
      m_hready    = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         check($sformatf("t4_stall%0d_haddr", k), o_m_haddr[1], 32'h2000_0000);
         check($sformatf("t4_stall%0d_htrans", k), 32'(o_m_htrans[1]), 32'h2);
         check($sformatf("t4_stall%0d_p0_hready", k), 32'(o_p0_hready[1]), 32'h0);
         advance();
      end
      m_hready = 1'b1;
      settle();
      check("t4_release_haddr", o_m_haddr[1], 32'h2000_0000);
      advance();
      set_port(0, HTRANS_IDLE, 32'h0, 3'd0, 1'b0);
      settle();
      check("t4_p0_issue_haddr", o_m_haddr[1], 32'h0000_0104);
      check("t4_p0_hready_pend", 32'(o_p0_hready[1]), 32'h0);
      check("t4_p1_hwdata", o_m_hwdata[1], 32'h0BAD_F00D);
      advance();
      settle();
      check("t4_p0_hready_done", 32'(o_p0_hready[1]), 32'h1);
      advance();

      // Asynchronous reset while P1 is pending and a data phase is open.
      do_reset();
      both_request();
      set_port(0, HTRANS_IDLE, 32'h0, 3'd0, 1'b0);
      set_port(1, HTRANS_IDLE, 32'h0, 3'd0, 1'b0);
      settle();
      HRESETn = 1'b0;
      #1;
      for (int g = 0; g < 2; g++) begin
         check($sformatf("t6_%0d_htrans", g), 32'(o_m_htrans[g]), 32'h0);
         check($sformatf("t6_%0d_p0_hready", g), 32'(o_p0_hready[g]), 32'h1);
         check($sformatf("t6_%0d_p1_hready", g), 32'(o_p1_hready[g]), 32'h1);
      end
      model_reset();
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      set_port(0, HTRANS_NONSEQ, 32'h0000_0300, 3'd2, 1'b0);
      settle();
      check("t6_first_haddr", o_m_haddr[1], 32'h0000_0300);
      check("t6_first_p0_hready", 32'(o_p0_hready[1]), 32'h1);
      advance();
      set_port(0, HTRANS_IDLE, 32'h0, 3'd0, 1'b0);
      settle();
      check("t6_first_dp_hready", 32'(o_p0_hready[1]), 32'h1);
      advance();

      // Continuous requests from both ports: round-robin owners alternate from P0.
      do_reset();
      for (int n = 0; n < 8; n++) exp_q.push_back(1'(n % 2));
      set_port(0, HTRANS_NONSEQ, 32'h0000_1000, 3'd2, 1'b0);
      set_port(1, HTRANS_NONSEQ, 32'h2000_1000, 3'd2, 1'b1);
      for (int n = 0; n < 8; n++) begin
         logic [0:0] want;
         settle();
         want = exp_q.pop_front();
         check($sformatf("t3_rr%0d_htrans", n), 32'(o_m_htrans[1]), 32'h2);
         check($sformatf("t3_rr%0d_owner", n), 32'(o_m_haddr[1][29]), 32'(want));
         advance();
         for (int p = 0; p < 2; p++) begin
            if (exp_hr[1][p]) begin
               p_haddr[p]  = p_haddr[p] + 32'h4;
               p_hwdata[p] = $urandom;
            end
         end
      end

      // Randomised traffic: masters follow the protocol as seen by the round-robin instance.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         m_hready = ($urandom_range(0, 3) != 0);
         m_hrdata = $urandom;
         settle();
         advance();
         for (int p = 0; p < 2; p++) begin
            if (exp_hr[1][p]) begin
               int r;
               r      = $urandom_range(0, 9);
               active = (r >= 4);
               p_hwdata[p] = $urandom;
               set_port(p, (r < 3) ? HTRANS_IDLE : (r == 3) ? HTRANS_BUSY :
                           (r < 8) ? HTRANS_NONSEQ : HTRANS_SEQ,
                        active ? ($urandom & 32'hFFFF_FFFC) : 32'h0,
                        3'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      fails++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
